// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg: shared state encoding and default divisor
package prog_clock_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DIV_C = 1;

endpackage

// File: rtl/prog_clock_divider_t_flip_flop_en.sv
// t_flip_flop_en: toggle flop with toggle-enable, sync clear and async reset
module t_flip_flop_en (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic q
);

    // clear has priority over toggle so a restart always begins low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (en) q <= ~q;
    end

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: programmable divide-by-N tick strobe and 50% divided clock
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             divclk,
    output logic             running
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

    state_t           state, state_d;
    logic [WIDTH-1:0] div_q;
    logic             wrap;

    // divisor zero parks the divider, any other value runs it
    always_comb begin
        state_d = load ? ((divisor == '0) ? IDLE : RUN) : state;
        wrap    = (state == RUN) && enable && !load && (count == div_q - WIDTH'(1));
    end

    // state and divisor change only on load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= (DEF != '0) ? RUN : IDLE;
            div_q <= DEF;
        end else begin
            state <= state_d;
            if (load) div_q <= divisor;
        end
    end

    // position counter and wrap strobe; IDLE keeps both at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (load || state == IDLE) count <= '0;
            else if (enable) count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

    t_flip_flop_en u_divclk (
        .clock (clock),
        .reset (reset),
        .en    (wrap),
        .clr   (load),
        .q     (divclk)
    );

    assign running = (state == RUN);

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] divisor;
    logic [3:0] count;
    logic       tick;
    logic       divclk;
    logic       running;
    int         checks = 0;
    int         errors = 0;

    localparam int EC3[6] = '{1, 2, 0, 1, 2, 0};
    localparam int ET3[6] = '{0, 0, 1, 0, 0, 1};
    localparam int ED3[6] = '{0, 0, 1, 1, 1, 0};

    prog_clock_divider #(.WIDTH(4), .DEFAULT_DIV(1)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .divisor (divisor),
        .count   (count),
        .tick    (tick),
        .divclk  (divclk),
        .running (running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [3:0] d);
        load    = 1'b1;
        divisor = d;
        step(1);
        load    = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        divisor = 4'd0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_divclk", 32'(divclk), 0);
        check("rst_running", 32'(running), 1);
        step(2);
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check($sformatf("n1_divclk_%0d", i), 32'(divclk), 32'(i % 2));
            check($sformatf("n1_tick_%0d", i), 32'(tick), 1);
            check($sformatf("n1_count_%0d", i), 32'(count), 0);
        end

        do_load(4'd3);
        divisor = 4'd7;
        check("n3_load_count", 32'(count), 0);
        check("n3_load_tick", 32'(tick), 0);
        check("n3_load_divclk", 32'(divclk), 0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("n3_count_%0d", i + 1), 32'(count), 32'(EC3[i]));
            check($sformatf("n3_tick_%0d", i + 1), 32'(tick), 32'(ET3[i]));
            check($sformatf("n3_divclk_%0d", i + 1), 32'(divclk), 32'(ED3[i]));
        end

        do_load(4'd4);
        step(2);
        check("gap_pre_count", 32'(count), 2);
        enable = 1'b0;
        step(2);
        check("gap_hold_count", 32'(count), 2);
        check("gap_hold_tick", 32'(tick), 0);
        enable = 1'b1;
        step(1);
        check("gap_c3_count", 32'(count), 3);
        check("gap_c3_tick", 32'(tick), 0);
        step(1);
        check("gap_wrap_count", 32'(count), 0);
        check("gap_wrap_tick", 32'(tick), 1);
        check("gap_wrap_divclk", 32'(divclk), 1);

        step(3);
        check("sim_pre_count", 32'(count), 3);
        do_load(4'd5);
        check("sim_count", 32'(count), 0);
        check("sim_tick", 32'(tick), 0);
        check("sim_divclk", 32'(divclk), 0);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check($sformatf("sim_notick_%0d", i), 32'(tick), 0);
        end
        step(1);
        check("sim_tick5", 32'(tick), 1);
        check("sim_count5", 32'(count), 0);
        check("sim_divclk5", 32'(divclk), 1);

        do_load(4'd0);
        check("idle_running", 32'(running), 0);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check($sformatf("idle_outs_%0d", i), 32'({running, count, tick, divclk}), 0);
        end
        do_load(4'd2);
        check("n2_running", 32'(running), 1);
        step(1);
        check("n2_tick1", 32'(tick), 0);
        check("n2_count1", 32'(count), 1);
        step(1);
        check("n2_tick2", 32'(tick), 1);
        check("n2_count2", 32'(count), 0);
        check("n2_divclk2", 32'(divclk), 1);

        do_load(4'd3);
        step(5);
        check("ar_pre_count", 32'(count), 2);
        check("ar_pre_divclk", 32'(divclk), 1);
        #2 reset = 1'b1;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_tick", 32'(tick), 0);
        check("ar_divclk", 32'(divclk), 0);
        #1 reset = 1'b0;
        step(1);
        check("ar_post_tick", 32'(tick), 1);
        check("ar_post_divclk", 32'(divclk), 1);
        step(1);
        check("ar_post_tick2", 32'(tick), 1);
        check("ar_post_divclk2", 32'(divclk), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
